// File: rtl/spi_command_dispatcher_if.sv
// Dispatcher bus: SPI byte stream from spi_secondary on one side,
// per-channel FIFO commit strobes, free-slot counts and status on the other.
interface spi_command_dispatcher_if #(
  parameter int Channels    = 2,
  parameter int RecordBytes = 4,
  parameter int SlotWidth   = 8
);
  logic                          cs;
  logic [7:0]                    rx_data;
  logic                          rx_valid;
  logic [7:0]                    tx_data;
  logic [Channels*SlotWidth-1:0] free_slots;
  logic [RecordBytes*8-1:0]      record_data;
  logic [Channels-1:0]           record_write;
  logic [Channels-1:0]           overflow;
  logic                          busy;

  modport master (
    output cs, rx_data, rx_valid, free_slots,
    input  tx_data, record_data, record_write, overflow, busy
  );

  modport slave (
    input  cs, rx_data, rx_valid, free_slots,
    output tx_data, record_data, record_write, overflow, busy
  );
endinterface

// File: rtl/spi_command_dispatcher.sv
// Decodes one command byte per CS frame, assembles whole motion records and
// commits them atomically to the addressed FIFO channel; also serves status.
module spi_command_dispatcher #(
  parameter int Channels    = 2,
  parameter int RecordBytes = 4,
  parameter int SlotWidth   = 8
) (
  input logic clk,
  input logic reset,
  spi_command_dispatcher_if.slave bus
);

  localparam int unsigned CntW = $clog2(RecordBytes + 1);

  typedef enum logic [1:0] {IDLE, STATUS, RECEIVE, DISCARD} state_t;

  state_t                   state_q, state_d;
  logic                     armed_q, armed_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [2:0]               ch_q, ch_d;
  logic [RecordBytes*8-1:0] rec_q, rec_d;
  logic [RecordBytes*8-1:0] record_data_q, record_data_d;
  logic [Channels-1:0]      record_write_q, record_write_d;
  logic [Channels-1:0]      overflow_q, overflow_d;
  logic [Channels-1:0]      sampled_q, sampled_d;
  logic [3:0]               idx_q, idx_d;
  logic [7:0]               tx_data_q, tx_data_d;

  function automatic logic [7:0] sat8(input logic [SlotWidth-1:0] v);
    logic [31:0] w;
    w = 32'(v);
    return (w > 32'd255) ? 8'hFF : w[7:0];
  endfunction

  always_comb begin
    state_d        = state_q;
    armed_d        = armed_q | bus.cs;
    cnt_d          = cnt_q;
    ch_d           = ch_q;
    rec_d          = rec_q;
    record_data_d  = record_data_q;
    record_write_d = '0;
    overflow_d     = overflow_q;
    sampled_d      = sampled_q;
    idx_d          = idx_q;
    tx_data_d      = tx_data_q;

    if (bus.cs) begin
      // Frame end: any partial or just-completed record is dropped.
      state_d = IDLE;
      cnt_d   = '0;
    end else if (bus.rx_valid) begin
      unique case (state_q)
        IDLE: begin
          // After reset a command is only accepted once cs has been seen high.
          if (armed_q) begin
            if (bus.rx_data[3:0] == 4'd1) begin
              state_d   = STATUS;
              idx_d     = '0;
              sampled_d = overflow_q;
            end else if (bus.rx_data[3:0] == 4'd2 &&
                         32'(bus.rx_data[6:4]) < 32'(Channels)) begin
              state_d = RECEIVE;
              ch_d    = bus.rx_data[6:4];
              cnt_d   = '0;
            end else if (bus.rx_data[3:0] != 4'd0) begin
              state_d = DISCARD;
            end
          end
        end
        STATUS: begin
          if (idx_q == 4'd0) overflow_d = overflow_q & ~sampled_q;
          if (32'(idx_q) < 32'(Channels + 1)) idx_d = idx_q + 4'd1;
        end
        RECEIVE: begin
          for (int unsigned i = 0; i < RecordBytes; i++) begin
            if (cnt_q == CntW'(i)) rec_d[i*8 +: 8] = bus.rx_data;
          end
          if (cnt_q == CntW'(RecordBytes - 1)) begin
            cnt_d = '0;
            // Overflow set after the status clear so a same-cycle event wins.
            for (int unsigned c = 0; c < Channels; c++) begin
              if (ch_q == 3'(c)) begin
                if (bus.free_slots[c*SlotWidth +: SlotWidth] != '0) begin
                  record_write_d[c] = 1'b1;
                  record_data_d     = rec_d;
                end else begin
                  overflow_d[c] = 1'b1;
                end
              end
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        DISCARD: ;
        default: ;
      endcase
    end

    unique case (state_d)
      IDLE: tx_data_d = sat8(bus.free_slots[SlotWidth-1:0]);
      STATUS: begin
        if (state_q != STATUS || bus.rx_valid) begin
          tx_data_d = 8'h00;
          if (idx_d == 4'd0) begin
            tx_data_d = 8'(sampled_d);
          end else begin
            for (int unsigned c = 0; c < Channels; c++) begin
              if (idx_d == 4'(c + 1)) tx_data_d = sat8(bus.free_slots[c*SlotWidth +: SlotWidth]);
            end
          end
        end
      end
      default: tx_data_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      armed_q        <= 1'b0;
      cnt_q          <= '0;
      ch_q           <= '0;
      rec_q          <= '0;
      record_data_q  <= '0;
      record_write_q <= '0;
      overflow_q     <= '0;
      sampled_q      <= '0;
      idx_q          <= '0;
      tx_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      armed_q        <= armed_d;
      cnt_q          <= cnt_d;
      ch_q           <= ch_d;
      rec_q          <= rec_d;
      record_data_q  <= record_data_d;
      record_write_q <= record_write_d;
      overflow_q     <= overflow_d;
      sampled_q      <= sampled_d;
      idx_q          <= idx_d;
      tx_data_q      <= tx_data_d;
    end
  end

  assign bus.tx_data      = tx_data_q;
  assign bus.record_data  = record_data_q;
  assign bus.record_write = record_write_q;
  assign bus.overflow     = overflow_q;
  assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_spi_command_dispatcher.sv
// Self-checking bench for spi_command_dispatcher: directed frames plus random
// frames checked against a frame-level reference model.
module tb_spi_command_dispatcher;
  localparam int CH = 2;
  localparam int RB = 4;
  localparam int SW = 10;

  logic clk;
  logic reset;
  int   checks;
  int   passes;
  int   strobe_cnt;
  int   model_strobes;
  int   free_m[CH];
  logic [CH-1:0]   model_ovf;
  logic [RB*8-1:0] model_rd;
  logic [7:0]      pl[$];

  spi_command_dispatcher_if #(.Channels(CH), .RecordBytes(RB), .SlotWidth(SW)) bus ();

  spi_command_dispatcher #(.Channels(CH), .RecordBytes(RB), .SlotWidth(SW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) strobe_cnt += $countones(bus.record_write);

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  function automatic logic [7:0] sat8(input int v);
    return (v > 255) ? 8'hFF : 8'(v);
  endfunction

  task automatic set_free();
    for (int c = 0; c < CH; c++) bus.free_slots[c*SW +: SW] = SW'(free_m[c]);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int g;
    g = $urandom_range(0, 2);
    repeat (g) tick();
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  // One complete CS frame: command byte followed by the bytes in pl.
  task automatic run_frame(input logic [7:0] cmd);
    int op, ch, kind, cnt, k;
    logic [CH-1:0]   sampled, exp_rw;
    logic [RB*8-1:0] acc;
    logic [7:0]      exp_tx;
    op = int'(cmd[3:0]); ch = int'(cmd[6:4]); cnt = 0; k = 0; acc = '0;
    kind = (op == 0) ? 0 : (op == 1) ? 1 : (op == 2 && ch < CH) ? 2 : 3;
    bus.cs = 1'b0;
    tick();
    send_byte(cmd);
    sampled = model_ovf;
    exp_tx = (kind == 0) ? sat8(free_m[0]) : (kind == 1) ? 8'(sampled) : 8'h00;
    checks++; if (bus.busy !== (kind != 0)) $display("FAIL busy_after_cmd %h: got %b want %b", cmd, bus.busy, kind != 0); else passes++;
    checks++; if (bus.tx_data !== exp_tx) $display("FAIL tx_after_cmd %h: got %h want %h", cmd, bus.tx_data, exp_tx); else passes++;
    foreach (pl[i]) begin
      send_byte(pl[i]);
      exp_rw = '0;
      exp_tx = 8'h00;
      if (kind == 2) begin
        acc[cnt*8 +: 8] = pl[i];
        cnt++;
        if (cnt == RB) begin
          cnt = 0;
          if (free_m[ch] != 0) begin
            exp_rw[ch] = 1'b1;
            model_rd = acc;
            model_strobes++;
          end else begin
            model_ovf[ch] = 1'b1;
          end
        end
      end else if (kind == 1) begin
        if (k == 0) model_ovf = model_ovf & ~sampled;
        if (k < CH + 1) k++;
        exp_tx = (k <= CH) ? sat8(free_m[k-1]) : 8'h00;
      end
      checks++; if (bus.record_write !== exp_rw) $display("FAIL record_write cmd %h byte %0d: got %b want %b", cmd, i, bus.record_write, exp_rw); else passes++;
      checks++; if (bus.record_data !== model_rd) $display("FAIL record_data cmd %h byte %0d: got %h want %h", cmd, i, bus.record_data, model_rd); else passes++;
      checks++; if (bus.tx_data !== exp_tx) $display("FAIL tx_data cmd %h byte %0d: got %h want %h", cmd, i, bus.tx_data, exp_tx); else passes++;
      checks++; if (bus.overflow !== model_ovf) $display("FAIL overflow cmd %h byte %0d: got %b want %b", cmd, i, bus.overflow, model_ovf); else passes++;
    end
    bus.cs = 1'b1;
    tick();
    checks++; if (bus.busy !== 1'b0) $display("FAIL busy_after_cs %h: got %b want 0", cmd, bus.busy); else passes++;
    checks++; if (bus.tx_data !== sat8(free_m[0])) $display("FAIL tx_idle_after_cs %h: got %h want %h", cmd, bus.tx_data, sat8(free_m[0])); else passes++;
    checks++; if (bus.record_write !== '0) $display("FAIL record_write_after_cs %h: got %b want 0", cmd, bus.record_write); else passes++;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.cs = 1'b1; bus.rx_valid = 1'b0; bus.rx_data = '0;
    free_m[0] = 16; free_m[1] = 20; set_free();
    repeat (3) tick();
    checks++; if (bus.tx_data !== 8'h00) $display("FAIL reset_tx: got %h want 00", bus.tx_data); else passes++;
    checks++; if (bus.record_write !== '0) $display("FAIL reset_record_write: got %b want 0", bus.record_write); else passes++;
    checks++; if (bus.overflow !== '0) $display("FAIL reset_overflow: got %b want 0", bus.overflow); else passes++;
    checks++; if (bus.record_data !== '0) $display("FAIL reset_record_data: got %h want 0", bus.record_data); else passes++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else passes++;
    reset = 1'b0;
    model_ovf = '0; model_rd = '0;
    tick();
  endtask

  task automatic test_back_to_back();
    free_m[0] = 16; set_free();
    pl = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_frame(8'h02);
    checks++; if (model_rd !== 32'h08070605) $display("FAIL b2b_model: got %h want 08070605", model_rd); else passes++;
    checks++; if (bus.record_data !== 32'h08070605) $display("FAIL b2b_record_data: got %h want 08070605", bus.record_data); else passes++;
  endtask

  task automatic test_abort_partial();
    logic [7:0] b;
    free_m[1] = 7; set_free();
    pl = {8'hA1, 8'hA2, 8'hA3};
    run_frame(8'h12);
    // Final byte arriving together with cs high must be dropped.
    bus.cs = 1'b0; tick();
    send_byte(8'h12);
    for (int i = 0; i < RB - 1; i++) send_byte(8'(8'hB0 + i));
    bus.rx_data = 8'hBF; bus.rx_valid = 1'b1; bus.cs = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    tick();
    checks++; if (bus.record_data !== model_rd) $display("FAIL cs_priority_data: got %h want %h", bus.record_data, model_rd); else passes++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL cs_priority_busy: got %b want 0", bus.busy); else passes++;
    pl = {};
    for (int i = 0; i < RB; i++) begin b = 8'($urandom); pl.push_back(b); end
    run_frame(8'h12);
    checks++; if (bus.record_data !== {pl[3], pl[2], pl[1], pl[0]}) $display("FAIL abort_new_record: got %h want %h", bus.record_data, {pl[3], pl[2], pl[1], pl[0]}); else passes++;
    checks++; if (strobe_cnt !== model_strobes) $display("FAIL abort_strobe_count: got %0d want %0d", strobe_cnt, model_strobes); else passes++;
  endtask

  task automatic test_overflow_status();
    free_m[0] = 33; free_m[1] = 0; set_free();
    pl = {8'h11, 8'h22, 8'h33, 8'h44};
    run_frame(8'h12);
    checks++; if (bus.overflow !== 2'b10) $display("FAIL overflow_ch1: got %b want 10", bus.overflow); else passes++;
    pl = {8'h00, 8'h00, 8'h00};
    run_frame(8'h01);
    pl = {8'h00};
    run_frame(8'h01);
    checks++; if (bus.overflow !== 2'b00) $display("FAIL overflow_cleared: got %b want 00", bus.overflow); else passes++;
  endtask

  task automatic test_discard();
    free_m[0] = 9; free_m[1] = 9; set_free();
    pl = {8'h01, 8'h02, 8'h03, 8'h04};
    run_frame(8'h72);
    pl = {8'h02, 8'h12};
    run_frame(8'h05);
    checks++; if (strobe_cnt !== model_strobes) $display("FAIL discard_strobe_count: got %0d want %0d", strobe_cnt, model_strobes); else passes++;
  endtask

  task automatic test_idle_tx();
    int vals[5];
    vals = '{300, 5, 255, 256, 0};
    foreach (vals[i]) begin
      free_m[0] = vals[i]; set_free();
      tick(); tick();
      checks++; if (bus.tx_data !== sat8(vals[i])) $display("FAIL idle_tx slots %0d: got %h want %h", vals[i], bus.tx_data, sat8(vals[i])); else passes++;
    end
  endtask

  task automatic test_reset_midframe();
    free_m[0] = 16; set_free();
    bus.cs = 1'b0; tick();
    send_byte(8'h02);
    send_byte(8'hC1); send_byte(8'hC2);
    reset = 1'b1; tick();
    checks++; if (bus.tx_data !== 8'h00) $display("FAIL midreset_tx: got %h want 00", bus.tx_data); else passes++;
    checks++; if (bus.record_data !== '0) $display("FAIL midreset_record_data: got %h want 0", bus.record_data); else passes++;
    reset = 1'b0;
    model_ovf = '0; model_rd = '0;
    send_byte(8'hC3); send_byte(8'hC4);
    send_byte(8'h02);
    for (int i = 0; i < RB; i++) begin
      send_byte(8'(8'hD0 + i));
      checks++; if (bus.record_write !== '0) $display("FAIL midreset_no_strobe %0d: got %b want 0", i, bus.record_write); else passes++;
      checks++; if (bus.busy !== 1'b0) $display("FAIL midreset_busy %0d: got %b want 0", i, bus.busy); else passes++;
    end
    checks++; if (bus.overflow !== '0) $display("FAIL midreset_overflow: got %b want 0", bus.overflow); else passes++;
    checks++; if (bus.record_data !== '0) $display("FAIL midreset_data_after: got %h want 0", bus.record_data); else passes++;
    bus.cs = 1'b1; tick();
    pl = {8'hE1, 8'hE2, 8'hE3, 8'hE4};
    run_frame(8'h02);
  endtask

  task automatic test_random();
    int op, n, sel;
    logic [7:0] cmd;
    for (int f = 0; f < 40; f++) begin
      for (int c = 0; c < CH; c++) free_m[c] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 1023));
      set_free();
      sel = $urandom_range(0, 5);
      op = (sel == 0) ? 0 : (sel == 1) ? 1 : (sel <= 4) ? 2 : int'($urandom_range(3, 15));
      cmd = {1'($urandom), 3'($urandom_range(0, 3)), 4'(op)};
      n = (op == 0) ? 0 : (op == 1) ? int'($urandom_range(0, CH + 3)) :
          (op == 2) ? int'($urandom_range(0, 3 * RB)) : int'($urandom_range(0, 5));
      pl = {};
      for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
      run_frame(cmd);
    end
    checks++; if (strobe_cnt !== model_strobes) $display("FAIL random_strobe_count: got %0d want %0d", strobe_cnt, model_strobes); else passes++;
  endtask

  initial begin
    checks = 0; passes = 0; strobe_cnt = 0; model_strobes = 0;
    model_ovf = '0; model_rd = '0;
    bus.free_slots = '0;
    test_reset();
    test_back_to_back();
    test_abort_partial();
    test_overflow_status();
    test_discard();
    test_idle_tx();
    test_reset_midframe();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/spi_command_dispatcher.md
Name: spi_command_dispatcher

Overview:
- Parametrised successor of the single-FIFO SPI command FSM.
- Sits between spi_secondary (byte stream) and N motion-segment FIFOs.
- Decodes a command byte per CS frame, assembles whole records internally and commits them atomically to the addressed channel; partial records are never written.
- Serves a multi-byte status stream: overflow flags plus free slots per channel.

Parameters:
- Channels, 2, number of FIFO channels (1..8).
- RecordBytes, 4, bytes per motion record (2..16).
- SlotWidth, 8, width of each channel's free-slot count.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cs  in  1  SPI chip select, active low; high = no frame.
- rx_data  in  8  byte received from spi_secondary.
- rx_valid  in  1  one-cycle strobe, rx_data valid.
- tx_data  out  8  byte spi_secondary shifts out on the next byte.
- free_slots  in  Channels*SlotWidth  free record slots per channel; channel c at [c*SlotWidth +: SlotWidth].
- record_data  out  RecordBytes*8  assembled record; first received byte in bits [7:0].
- record_write  out  Channels  one-hot, one-cycle commit strobe per channel.
- overflow  out  Channels  sticky per-channel "record dropped, FIFO full".
- busy  out  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset: state=IDLE; tx_data=0; record_write=0; overflow=0; record_data=0; byte counter=0; channel register=0.
- cs high, any cycle: state->IDLE, byte counter cleared; no commit. A partial record is discarded; a record completed in the same cycle is also dropped. Takes priority over rx_valid.
- Command byte: the first rx_valid with cs low in IDLE. Opcode = rx_data[3:0]; channel = rx_data[6:4]; rx_data[7] is reserved.
- Opcode 0 (NO_OP): stay in IDLE.
- Opcode 1 (STATUS): go to STATUS; status index = 0.
- Opcode 2 (WRITE_FIFO) with channel < Channels: go to RECEIVE, latch the channel.
- Opcode 2 with channel >= Channels, or any other opcode: go to DISCARD. DISCARD ignores all bytes until cs goes high.
- RECEIVE, each rx_valid:
  - Store the byte at position byte counter, increment the counter.
  - On the byte that makes counter==RecordBytes, next cycle:
    - If free_slots[ch] != 0: record_write[ch]=1 for exactly 1 cycle, record_data holds the record.
    - Else: overflow[ch] is set and no strobe is issued.
  - Counter wraps to 0 and the state stays RECEIVE, so back-to-back records are allowed.
- Commit latency: 1 clk after the final rx_valid. record_data stays stable until the next commit.
- IDLE tx_data: free slots of channel 0, saturated to 8 bits (keeps the single-channel host protocol working). Updated every cycle.
- STATUS tx_data, updated in the cycle after each rx_valid:
  - Index 0: flags byte, bit c = overflow[c]; unused bits 0.
  - Index 1..Channels: free_slots[index-1] saturated to 255.
  - Beyond that: 0x00.
  - Index saturates at Channels+1.
  - The overflow bits sampled into the flags byte are cleared when the rx_valid that advances past index 0 occurs.
  - An overflow event in that same cycle wins, and its bit stays set.
- tx_data in RECEIVE and DISCARD: 0x00.
- reset mid-frame: behaves like reset; the FSM stays IDLE until cs rises and falls again. A command byte is not accepted until cs has been seen high once.

Test Plan:
- Reset, cs low, send 0x02 then 8 bytes 01..08, free_slots ch0=16 -> record_write=01 twice, record_data 0x04030201 then 0x08070605, each 1 clk after the 4th/8th byte.
- Send 0x12 then 3 bytes, raise cs -> no record_write pulse; next frame 0x12 + 4 bytes -> one record_write=10 with only the new bytes.
- Channel 1 free_slots=0, send 0x12 + 4 bytes -> no strobe, overflow=10. Then STATUS frame (0x01 + 3 dummies) -> tx_data sequence 0x02, ch0 slots, ch1 slots=0x00. A following STATUS frame -> flags 0x00.
- Send 0x72 (channel 7 ≥ Channels=2) + 4 bytes -> DISCARD, no strobe, tx_data=0x00, busy high until cs high.
- IDLE with free_slots ch0=300 (SlotWidth=10) -> tx_data=0xFF. With 5 -> 0x05.
- reset asserted after 2 bytes of a record, then 2 more bytes while cs stays low -> no strobe, state IDLE, all outputs at reset values.
